// File: rtl/sync_ram_pkg.sv
// Shared types and constants for the sync_ram scratch memory.
// SYNC_RAM_OUT_REG_EN selects the extra output register stage and thus the read latency.
package sync_ram_pkg;

   typedef enum logic {INIT, RUN} ram_state_t;

   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;

`ifdef SYNC_RAM_OUT_REG_EN
   localparam int RD_LATENCY = 2;
`else
   localparam int RD_LATENCY = 1;
`endif

endpackage

// File: rtl/sync_ram_init.sv
// Post-reset fill sequencer: walks every address once, then releases the RAM to the user.
module sync_ram_init
   import sync_ram_pkg::*;
#(
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   output logic              init_we,
   output logic [ADDR_W-1:0] init_addr,
   output logic              busy
);

   ram_state_t        state;
   logic [ADDR_W:0]   count;
   logic [ADDR_W:0]   count_next;

   assign count_next = count + {{ADDR_W{1'b0}}, 1'b1};

   // The extra counter bit flags completion, so any depth exits without a compare
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
         count <= '0;
         busy  <= 1'b1;
      end else begin
         case (state)
            INIT: begin
               count <= count_next;
               if (count_next[ADDR_W]) begin
                  state <= RUN;
                  busy  <= 1'b0;
               end
            end
            RUN: begin
               busy <= 1'b0;
            end
            default: begin
               state <= INIT;
               count <= '0;
               busy  <= 1'b1;
            end
         endcase
      end
   end

   assign init_we   = busy && !rst;
   assign init_addr = count[ADDR_W-1:0];

endmodule

// File: rtl/sync_ram.sv
// Single-port synchronous RAM with registered read, selectable read-during-write and power-up fill.
// Define SYNC_RAM_OUT_REG_EN to add a second output register stage (read latency 2).
module sync_ram
   import sync_ram_pkg::*;
#(
   parameter int              ADDR_W   = 3,
   parameter int              DATA_W   = 16,
   parameter logic [DATA_W-1:0] INIT_VAL = '0,
   parameter int              RDW_MODE = RDW_READ_FIRST
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              busy
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              init_we;
   logic [ADDR_W-1:0] init_addr;
   logic              accept;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] s1_data;
   logic              s1_valid;

   sync_ram_init #(
      .ADDR_W (ADDR_W)
   ) u_init (
      .clk       (clk),
      .rst       (rst),
      .init_we   (init_we),
      .init_addr (init_addr),
      .busy      (busy)
   );

   assign accept = en && !busy && !rst;

   // The fill sequencer owns the write port until it releases busy
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = addr;
      wr_data = din;
      if (busy) begin
         wr_en   = init_we;
         wr_addr = init_addr;
         wr_data = INIT_VAL;
      end else if (accept && we) begin
         wr_en = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = (we && (RDW_MODE == RDW_WRITE_FIRST)) ? din : mem[addr];

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_data  <= '0;
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_data <= rd_data;
         end
      end
   end

`ifdef SYNC_RAM_OUT_REG_EN
   logic [DATA_W-1:0] s2_data;
   logic              s2_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_data  <= '0;
         s2_valid <= 1'b0;
      end else begin
         s2_data  <= s1_data;
         s2_valid <= s1_valid;
      end
   end

   assign dout       = s2_data;
   assign dout_valid = s2_valid;
`else
   assign dout       = s1_data;
   assign dout_valid = s1_valid;
`endif

endmodule

// File: tb/tb_sync_ram.sv
// Scoreboard bench for sync_ram: one read-first and one write-first instance share the stimulus.
module tb_sync_ram;
   import sync_ram_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic        we  = 1'b0;
   logic [2:0]  addr = '0;
   logic [15:0] din  = '0;

   logic [15:0] dout_rf, dout_wf;
   logic        valid_rf, valid_wf, busy_rf, busy_wf;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [15:0] data;
      int          due;
   } exp_t;

   exp_t        q_rf[$];
   exp_t        q_wf[$];
   exp_t        e_rf, e_wf;
   logic [15:0] model [8];

   sync_ram #(.ADDR_W(3), .DATA_W(16), .INIT_VAL(16'hA5A5), .RDW_MODE(RDW_READ_FIRST)) u_rf (
      .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din),
      .dout(dout_rf), .dout_valid(valid_rf), .busy(busy_rf));

   sync_ram #(.ADDR_W(3), .DATA_W(16), .INIT_VAL(16'hA5A5), .RDW_MODE(RDW_WRITE_FIRST)) u_wf (
      .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din),
      .dout(dout_wf), .dout_valid(valid_wf), .busy(busy_wf));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitors: every valid pulse must match the oldest expectation, on its due cycle
   always @(negedge clk) begin
      if (valid_rf === 1'b1) begin
         if (q_rf.size() == 0) begin
            check("rf_unexpected_valid", 32'd1, 32'd0);
         end else begin
            e_rf = q_rf.pop_front();
            check("rf_data", {16'd0, dout_rf}, {16'd0, e_rf.data});
            check("rf_due_cycle", cyc, e_rf.due);
         end
      end else if (q_rf.size() > 0 && q_rf[0].due <= cyc) begin
         e_rf = q_rf.pop_front();
         check("rf_missing_valid", 32'd0, 32'd1);
      end
   end

   always @(negedge clk) begin
      if (valid_wf === 1'b1) begin
         if (q_wf.size() == 0) begin
            check("wf_unexpected_valid", 32'd1, 32'd0);
         end else begin
            e_wf = q_wf.pop_front();
            check("wf_data", {16'd0, dout_wf}, {16'd0, e_wf.data});
            check("wf_due_cycle", cyc, e_wf.due);
         end
      end else if (q_wf.size() > 0 && q_wf[0].due <= cyc) begin
         e_wf = q_wf.pop_front();
         check("wf_missing_valid", 32'd0, 32'd1);
      end
   end

   task automatic applyStimulus(input logic w, input logic [2:0] a, input logic [15:0] d);
      en   = 1'b1;
      we   = w;
      addr = a;
      din  = d;
      if (w) begin
         q_rf.push_back('{data: model[a], due: cyc + RD_LATENCY});
         q_wf.push_back('{data: d,        due: cyc + RD_LATENCY});
         model[a] = d;
      end else begin
         q_rf.push_back('{data: model[a], due: cyc + RD_LATENCY});
         q_wf.push_back('{data: model[a], due: cyc + RD_LATENCY});
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      en = 1'b0;
      we = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic checkOutput(input string name, input logic [15:0] exp_dout,
                              input logic exp_valid, input logic exp_busy);
      @(negedge clk);
      check({name, "_dout_rf"},  {16'd0, dout_rf}, {16'd0, exp_dout});
      check({name, "_dout_wf"},  {16'd0, dout_wf}, {16'd0, exp_dout});
      check({name, "_valid_rf"}, {31'd0, valid_rf}, {31'd0, exp_valid});
      check({name, "_valid_wf"}, {31'd0, valid_wf}, {31'd0, exp_valid});
      check({name, "_busy_rf"},  {31'd0, busy_rf},  {31'd0, exp_busy});
      check({name, "_busy_wf"},  {31'd0, busy_wf},  {31'd0, exp_busy});
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      for (int i = 0; i < 8; i++) model[i] = 16'hA5A5;

      repeat (2) begin
         @(posedge clk); #1;
      end
      checkOutput("reset", 16'h0000, 1'b0, 1'b1);

      // Release reset with a write request pending; busy must swallow it for 8 cycles
      rst  = 1'b0;
      en   = 1'b1;
      we   = 1'b1;
      addr = 3'd0;
      din  = 16'hFFFF;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("init_busy_rf", {31'd0, busy_rf}, 32'd1);
         check("init_busy_wf", {31'd0, busy_wf}, 32'd1);
         @(posedge clk); #1;
      end
      en = 1'b0;
      we = 1'b0;
      @(negedge clk);
      check("init_done_rf", {31'd0, busy_rf}, 32'd0);
      check("init_done_wf", {31'd0, busy_wf}, 32'd0);
      @(posedge clk); #1;

      for (int a = 0; a < 8; a++) applyStimulus(1'b0, 3'(a), 16'h0000);

      applyStimulus(1'b1, 3'd3, 16'h1234);
      applyStimulus(1'b1, 3'd7, 16'hBEEF);
      applyStimulus(1'b0, 3'd3, 16'h0000);
      applyStimulus(1'b0, 3'd7, 16'h0000);

      applyStimulus(1'b1, 3'd5, 16'h0001);
      applyStimulus(1'b1, 3'd5, 16'h0002);
      applyStimulus(1'b0, 3'd5, 16'h0000);

      idle(RD_LATENCY + 1);
      repeat (3) checkOutput("hold", 16'h0002, 1'b0, 1'b0);

      applyStimulus(1'b1, 3'd2, 16'h1234);
      idle(RD_LATENCY + 1);
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("mid_reset", 16'h0000, 1'b0, 1'b1);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) model[i] = 16'hA5A5;
      n = 0;
      while (busy_rf && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("reinit_len", n, 32'd8);
      check("reinit_done_wf", {31'd0, busy_wf}, 32'd0);

      applyStimulus(1'b0, 3'd2, 16'h0000);
      applyStimulus(1'b0, 3'd3, 16'h0000);
      idle(RD_LATENCY + 2);

      check("rf_queue_drained", q_rf.size(), 32'd0);
      check("wf_queue_drained", q_wf.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sync_ram.md
# sync_ram

Parametrised single-port synchronous RAM, the successor to the fixed 8×16 combinational ROM. It adds:
- write capability and a registered read path;
- a selectable read-during-write policy;
- a self-clearing initialisation sequencer that fills every word with a programmable value after reset.

It sits wherever a datapath needs small scratch storage with deterministic power-up contents (lookup tables, register files, coefficient stores).

## Interface
Parameters:
- ADDR_W, 3, address width; depth = 2**ADDR_W
- DATA_W, 16, word width
- INIT_VAL, 0, DATA_W-bit value written to every word by the init sequencer
- RDW_MODE, 0, read-during-write policy: 0 = read-first (old data), 1 = write-first (new data)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- en  in  1  access request, sampled when busy=0
- we  in  1  write enable, qualified by en
- addr  in  ADDR_W  word address
- din  in  DATA_W  write data
- dout  out  DATA_W  read data, registered
- dout_valid  out  1  one-cycle pulse, dout carries data of an accepted access
- busy  out  1  high while init sequence runs; requests ignored

## Operation
- States: INIT, RUN.
- rst=1 forces INIT and init counter = 0; dout=0, dout_valid=0, busy=1.
- INIT:
  - each cycle writes INIT_VAL to mem[counter], then increments the counter;
  - after writing address 2**ADDR_W-1, moves to RUN;
  - en/we/addr/din are ignored, and dout_valid stays 0.
- RUN:
  - en=1, we=0: mem[addr] is read into dout.
  - en=1, we=1: din is written to mem[addr]. dout also updates: RDW_MODE=0 gives the pre-write contents, RDW_MODE=1 gives din.
  - en=0: no access; dout holds its last value and dout_valid=0.
- Every accepted access (read or write) produces a dout_valid pulse.
- Address wrap: the counter is ADDR_W+1 bits wide; the INIT→RUN exit is decided on its MSB, so depth 2**ADDR_W needs no special case.
- Reset mid-operation (in either state) restarts INIT from address 0. Any contents written before the reset are overwritten.
- No X on outputs: dout is never loaded from an unwritten word, because INIT covers the whole depth.

## Timing
- Init duration: busy=1 from the reset cycle through 2**ADDR_W cycles after rst deasserts. busy falls on the edge that completes the last init write.
- Read latency: 1 cycle. Request at edge k produces dout/dout_valid valid after edge k+1 (2 cycles with the macro below).
- Throughput: one access per cycle, back-to-back, with no bubbles.
- Write timing: a write at edge k is visible to a read issued at edge k+1.

## Configuration
- SYNC_RAM_OUT_REG_EN defined: adds a second output register stage on dout and dout_valid.
  - read latency becomes 2;
  - both stages reset to 0;
  - busy is unchanged.
- Macro undefined: single registered stage, latency 1.

## Structure
- Package sync_ram_pkg holds:
  - state enum ram_state_t {INIT, RUN};
  - RDW_READ_FIRST = 0 and RDW_WRITE_FIRST = 1 constants;
  - a latency constant derived from SYNC_RAM_OUT_REG_EN.
- One sub-module, sync_ram_init:
  - contains the state register and address counter;
  - outputs init_we, init_addr and busy;
  - the top muxes between init and user write ports.
- Memory array and output registers live in the top, sync_ram.

## Test plan
All scenarios use ADDR_W=3, DATA_W=16, INIT_VAL=16'hA5A5 and latency 1 unless noted.
1. **Init sequence.** Pulse rst 1 cycle, then read 0..7.
   - busy is high for exactly 8 cycles after rst falls;
   - every read returns 16'hA5A5 with dout_valid high 1 cycle after each request.
2. **Write then read.** Write 16'h1234 @3 and 16'hBEEF @7, then read 3 and 7 back-to-back.
   - dout = 16'h1234 then 16'hBEEF on consecutive cycles.
3. **Read-during-write.** Location 5 holds 16'h0001; write 16'h0002 @5.
   - RDW_MODE=0: dout = 16'h0001;
   - RDW_MODE=1: dout = 16'h0002;
   - a following read of 5 returns 16'h0002 in both modes.
4. **Requests while busy and idle hold.** Assert en=1, we=1, din=16'hFFFF @0 while busy=1, then wait for busy to fall and read 0.
   - the read returns 16'hA5A5 and dout_valid stays 0 throughout busy;
   - with en=0 afterwards, dout holds its value and dout_valid stays 0.
5. **Mid-operation reset.** After writing 16'h1234 @2, assert rst.
   - busy reasserts, dout=0 and dout_valid=0;
   - after re-init, a read of 2 returns 16'hA5A5.
6. **Output register stage.** Repeat scenario 2 with SYNC_RAM_OUT_REG_EN defined.
   - data appears 2 cycles after each request, still back-to-back with no bubbles.
